status_reg: RTL and testbench

STATUS_REG -- requirements
Module: status_reg

---
 rtl/status_reg.sv | 65 ++++++
 tb/tb_status_reg.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/status_reg.sv
// status_reg: 6502-style processor status register with delayed IRQ mask
module status_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [7:0] alu_res,
  input  logic       alu_cout,
  input  logic       alu_ovf,
  input  logic [7:0] data_in,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_op,
  input  logic       load_p,
  input  logic       rti_load,
  input  logic       set_c,
  input  logic       clr_c,
  input  logic       set_i,
  input  logic       clr_i,
  input  logic       set_d,
  input  logic       clr_d,
  input  logic       clr_v,
  input  logic       poll,
  input  logic       push_b,
  output logic       flag_n,
  output logic       flag_v,
  output logic       flag_d,
  output logic       flag_i,
  output logic       flag_z,
  output logic       flag_c,
  output logic [7:0] p_out,
  output logic       irq_mask,
  output logic       c_to_alu
);
  logic n_q, v_q, d_q, i_q, z_q, c_q, irq_mask_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d, irq_mask_d;
  logic ld, zero;
  // next flags: pull beats explicit set/clr, which beats BIT, which beats ALU strobes
  always_comb begin
    ld = load_p | rti_load;
    zero = alu_res == 8'h00;
    n_d = !ce ? n_q : ld ? data_in[7] : bit_op ? data_in[7] : upd_nz ? alu_res[7] : n_q;
    v_d = !ce ? v_q : ld ? data_in[6] : clr_v ? 1'b0 : bit_op ? data_in[6] : upd_v ? alu_ovf : v_q;
    d_d = !ce ? d_q : ld ? data_in[3] : set_d ? 1'b1 : clr_d ? 1'b0 : d_q;
    i_d = !ce ? i_q : ld ? data_in[2] : set_i ? 1'b1 : clr_i ? 1'b0 : i_q;
    z_d = !ce ? z_q : ld ? data_in[1] : (bit_op | upd_nz) ? zero : z_q;
    c_d = !ce ? c_q : ld ? data_in[0] : set_c ? 1'b1 : clr_c ? 1'b0 : upd_c ? alu_cout : c_q;
    irq_mask_d = !ce ? irq_mask_q : rti_load ? data_in[2] : poll ? i_q : irq_mask_q;
  end
  // flag and mask registers, reset to I=1 with interrupts masked
  always_ff @(posedge clk) begin
    if (rst) begin
      {n_q, v_q, d_q, z_q, c_q} <= '0;
      i_q <= 1'b1;
      irq_mask_q <= 1'b1;
    end else begin
      {n_q, v_q, d_q, i_q, z_q, c_q} <= {n_d, v_d, d_d, i_d, z_d, c_d};
      irq_mask_q <= irq_mask_d;
    end
  end
  assign {flag_n, flag_v, flag_d, flag_i, flag_z, flag_c} = {n_q, v_q, d_q, i_q, z_q, c_q};
  assign p_out = {n_q, v_q, 1'b1, push_b, d_q, i_q, z_q, c_q};
  assign irq_mask = irq_mask_q;
  assign c_to_alu = c_q;
endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: scoreboard bench for status_reg against a layered-overwrite model
module tb_status_reg;
  logic clk = 0;
  logic rst, ce, alu_cout, alu_ovf, upd_nz, upd_c, upd_v, bit_op, load_p, rti_load;
  logic set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v, poll, push_b;
  logic [7:0] alu_res, data_in, p_out;
  logic flag_n, flag_v, flag_d, flag_i, flag_z, flag_c, irq_mask, c_to_alu;
  logic [7:0] mp;
  logic mm;
  logic [15:0] q[$];
  int n_chk = 0, n_fail = 0;

  status_reg dut (
    .clk(clk), .rst(rst), .ce(ce), .alu_res(alu_res), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .data_in(data_in), .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_op(bit_op),
    .load_p(load_p), .rti_load(rti_load), .set_c(set_c), .clr_c(clr_c), .set_i(set_i),
    .clr_i(clr_i), .set_d(set_d), .clr_d(clr_d), .clr_v(clr_v), .poll(poll), .push_b(push_b),
    .flag_n(flag_n), .flag_v(flag_v), .flag_d(flag_d), .flag_i(flag_i), .flag_z(flag_z),
    .flag_c(flag_c), .p_out(p_out), .irq_mask(irq_mask), .c_to_alu(c_to_alu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    {rst, alu_cout, alu_ovf, upd_nz, upd_c, upd_v, bit_op, load_p, rti_load} = '0;
    {set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v, poll, push_b} = '0;
    alu_res = 8'h00;
    data_in = 8'h00;
    ce = 1'b1;
  endtask

  task automatic cyc();
    logic [7:0] p, po;
    logic m;
    p = mp;
    m = mm;
    if (rst) begin
      p = 8'h04;
      m = 1'b1;
    end else if (ce) begin
      m = rti_load ? data_in[2] : poll ? mp[2] : mm;
      if (upd_nz) begin p[7] = alu_res[7]; p[1] = alu_res == 0; end
      if (upd_c) p[0] = alu_cout;
      if (upd_v) p[6] = alu_ovf;
      if (bit_op) begin p[7] = data_in[7]; p[6] = data_in[6]; p[1] = alu_res == 0; end
      if (clr_c) p[0] = 1'b0;
      if (set_c) p[0] = 1'b1;
      if (clr_i) p[2] = 1'b0;
      if (set_i) p[2] = 1'b1;
      if (clr_d) p[3] = 1'b0;
      if (set_d) p[3] = 1'b1;
      if (clr_v) p[6] = 1'b0;
      if (load_p || rti_load) p = data_in & 8'hCF;
    end
    mp = p;
    mm = m;
    po = p | 8'h20 | (push_b ? 8'h10 : 8'h00);
    q.push_back({p[7], p[6], p[3], p[2], p[1], p[0], m, p[0], po});
    @(negedge clk);
  endtask

  task automatic rnd();
    rst = $urandom_range(39) == 0;
    ce = $urandom_range(7) != 0;
    alu_res = $urandom_range(3) == 0 ? 8'h00 : 8'($urandom);
    data_in = 8'($urandom);
    {alu_cout, alu_ovf, push_b} = 3'($urandom);
    {upd_nz, upd_c, upd_v, bit_op} = {$urandom_range(2) == 0, $urandom_range(2) == 0,
                                      $urandom_range(2) == 0, $urandom_range(5) == 0};
    {load_p, rti_load, poll} = {$urandom_range(9) == 0, $urandom_range(11) == 0, $urandom_range(2) == 0};
    {set_c, clr_c, set_i, clr_i} = {$urandom_range(5) == 0, $urandom_range(5) == 0,
                                    $urandom_range(5) == 0, $urandom_range(5) == 0};
    {set_d, clr_d, clr_v} = {$urandom_range(5) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0};
  endtask

  // monitor: outputs are valid every cycle, compare just after each edge
  initial forever begin
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("scoreboard", {flag_n, flag_v, flag_d, flag_i, flag_z, flag_c, irq_mask, c_to_alu, p_out}, e);
    end
  end

  initial begin
    mp = 8'h00;
    mm = 1'b0;
    clr_in();
    @(negedge clk);
    rnd(); rst = 1; cyc();
    clr_in(); rst = 1; cyc();
    chk("reset_p_b0", {8'h00, p_out}, 16'h0024);
    chk("reset_mask", {15'h0, irq_mask}, 16'h0001);
    rst = 1; push_b = 1; cyc();
    chk("reset_p_b1", {8'h00, p_out}, 16'h0034);
    clr_in(); upd_nz = 1; upd_c = 1; alu_cout = 1; cyc();
    chk("nz_c_update", {8'h00, p_out}, 16'h0027);
    clr_in(); load_p = 1; data_in = 8'hFF; cyc();
    chk("load_ff_b0", {8'h00, p_out}, 16'h00EF);
    clr_in(); push_b = 1; cyc();
    chk("load_ff_b1", {8'h00, p_out}, 16'h00FF);
    clr_in(); load_p = 1; cyc();
    clr_in(); bit_op = 1; upd_nz = 1; data_in = 8'hC0; cyc();
    chk("bit_nvz", {13'h0, flag_n, flag_v, flag_z}, 16'h0007);
    clr_in(); set_i = 1; cyc();
    clr_in(); poll = 1; cyc();
    clr_in(); clr_i = 1; poll = 1; cyc();
    chk("cli_delay", {14'h0, flag_i, irq_mask}, 16'h0001);
    clr_in(); poll = 1; cyc();
    chk("cli_late", {15'h0, irq_mask}, 16'h0000);
    clr_in(); set_c = 1; clr_c = 1; upd_c = 1; cyc();
    chk("set_wins", {15'h0, flag_c}, 16'h0001);
    clr_in(); rti_load = 1; set_c = 1; poll = 1; cyc();
    chk("rti_c_mask", {14'h0, flag_c, irq_mask}, 16'h0000);
    clr_in(); ce = 0; data_in = 8'hFF; alu_res = 8'h80; {alu_cout, alu_ovf} = 2'b11;
    {upd_nz, upd_c, upd_v, bit_op, load_p, rti_load, poll} = '1;
    {set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v} = '1;
    cyc();
    chk("ce_hold", {7'h0, irq_mask, p_out}, 16'h0020);
    clr_in(); ce = 0; rst = 1; cyc();
    chk("reset_no_ce", {7'h0, irq_mask, p_out}, 16'h0124);
    clr_in(); load_p = 1; data_in = 8'hFF; cyc();
    clr_in(); rst = 1; load_p = 1; data_in = 8'hFF; cyc();
    chk("reset_over_load", {7'h0, irq_mask, p_out}, 16'h0124);
    repeat (400) begin rnd(); cyc(); end
    clr_in();
    repeat (2) @(negedge clk);
    chk("drain", 16'(q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
